// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the imem/dmem unified memory port arbiter.
// State encodings, requester IDs, abort data and the round-robin pick.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IBUSY = 2'd1,
    ST_DBUSY = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IMEM = 1'b0,
    GNT_DMEM = 1'b1
  } gnt_t;

  localparam logic [31:0] ERR_DATA  = 32'hDEADBEEF;
  localparam logic [1:0]  MASK_WORD = 2'd2;

  // A tie goes to whichever side did not win last time.
  function automatic gnt_t rr_pick(
    input logic i_v,
    input logic d_v,
    input gnt_t last
  );
    gnt_t g;
    g = GNT_IMEM;
    unique case (1'b1)
      (i_v & d_v):  g = (last == GNT_IMEM) ? GNT_DMEM : GNT_IMEM;
      (d_v & ~i_v): g = GNT_DMEM;
      default:      g = GNT_IMEM;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter.
// Counts busy cycles since the last grant and flags the timeout cycle.
module mem_port_arbiter_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_busy,
  output logic o_expire
);

  localparam int LOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW    = (LOG_W > 8) ? LOG_W : 8;

  logic [CW-1:0] r_cnt;
  logic          w_last;

  // Busy cycle N sees a count of N-1, so the Nth busy cycle expires.
  assign w_last   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign o_expire = i_busy && w_last;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_busy && !w_last) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between imem and dmem.
// Optional watchdog abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  output logic              imem_good,
  output logic [DATA_W-1:0] imem_instr,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_valid,
  input  logic [DATA_W-1:0] dmem_writeData,
  input  logic              dmem_memRead,
  input  logic              dmem_memWrite,
  input  logic [1:0]        dmem_maskMode,
  input  logic              dmem_sext,
  output logic              dmem_good,
  output logic [DATA_W-1:0] dmem_readData,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_writeData,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic [1:0]        mem_maskMode,
  output logic              mem_sext,
  output logic              mem_valid,
  input  logic              mem_good,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              arb_err
);

  state_t r_state;
  state_t w_next;
  gnt_t   r_last;
  gnt_t   w_pick;

  logic              w_busy;
  logic              w_grant;
  logic              w_timeout;
  logic              w_abort;
  logic              w_done;
  logic [DATA_W-1:0] w_rsp;

  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rd;
  logic              r_wr;
  logic [1:0]        r_mask;
  logic              r_sext;

  assign w_pick  = rr_pick(imem_valid, dmem_valid, r_last);
  assign w_busy  = (r_state != ST_IDLE);
  assign w_grant = !w_busy && (imem_valid || dmem_valid);
  assign w_abort = w_timeout && !mem_good;
  assign w_done  = w_busy && (mem_good || w_abort);
  assign w_rsp   = w_abort ? DATA_W'(ERR_DATA) : mem_readData;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_last  <= GNT_IMEM;
    end else begin
      r_state <= w_next;
      if (w_grant) r_last <= w_pick;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant)
          w_next = (w_pick == GNT_DMEM) ? ST_DBUSY : ST_IBUSY;
      end
      ST_IBUSY, ST_DBUSY: begin
        if (w_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_good     = 1'b0;
    dmem_good     = 1'b0;
    imem_instr    = '0;
    dmem_readData = '0;
    if (w_done && r_state == ST_IBUSY) begin
      imem_good  = 1'b1;
      imem_instr = w_rsp;
    end
    if (w_done && r_state == ST_DBUSY) begin
      dmem_good     = 1'b1;
      dmem_readData = w_rsp;
    end
  end

  // Fetches are always full-word unsigned reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_mask  <= 2'd0;
      r_sext  <= 1'b0;
    end else if (w_grant) begin
      if (w_pick == GNT_DMEM) begin
        r_addr  <= dmem_addr;
        r_wdata <= dmem_writeData;
        r_rd    <= dmem_memRead;
        r_wr    <= dmem_memWrite;
        r_mask  <= dmem_maskMode;
        r_sext  <= dmem_sext;
      end else begin
        r_addr  <= imem_addr;
        r_wdata <= '0;
        r_rd    <= 1'b1;
        r_wr    <= 1'b0;
        r_mask  <= MASK_WORD;
        r_sext  <= 1'b0;
      end
    end
  end

  assign mem_valid     = w_busy;
  assign mem_addr      = r_addr;
  assign mem_writeData = r_wdata;
  assign mem_memRead   = r_rd;
  assign mem_memWrite  = r_wr;
  assign mem_maskMode  = r_mask;
  assign mem_sext      = r_sext;

`ifdef ARB_TIMEOUT_EN
  logic r_err;

  mem_port_arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clr   (w_grant),
    .i_busy  (w_busy),
    .o_expire(w_timeout)
  );

  always_ff @(posedge clock) begin
    if (reset) r_err <= 1'b0;
    else if (w_abort) r_err <= 1'b1;
  end

  assign arb_err = r_err;
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_timeout   = 1'b0;
  assign arb_err     = 1'b0;
`endif

endmodule
